lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 12, byte-address width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 req_valid  input  1  core requests an access this cycle.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  ADDR_WIDTH  byte address.
REQ-009 req_wdata  input  DATA_WIDTH  store data, little-endian, LSB-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-012 rsp_err  output  1  qualifies rsp_valid; request rejected, no memory access.
REQ-013 mem_ren, mem_wen  output  1 each  memory read and write enables.
REQ-014 mem_add  output  ADDR_WIDTH  memory byte address.
REQ-015 mem_datain  output  DATA_WIDTH  memory write word; byte at mem_add is bits [31:24].
REQ-016 mem_dataout  input  DATA_WIDTH  combinational memory read word, same byte order.

Function
REQ-017 FSM states SHALL be IDLE, RD, RMW_RD, WR, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready; request fields are registered at accept.
REQ-019 At accept, the next state SHALL be:
- RESP with error if the address or funct3 is illegal;
- RD for a load;
- WR for SW;
- RMW_RD for SB or SH.
REQ-020 An address is illegal if req_addr > 2^ADDR_WIDTH-4.
REQ-021 Illegal funct3 SHALL be 011, 110 or 111 for loads, and anything other than 000-010 for stores.
REQ-022 RD and RMW_RD SHALL drive mem_ren=1 and mem_add=addr, register mem_dataout, then go to RESP and WR respectively.
REQ-023 WR SHALL drive mem_wen=1 with mem_add=addr and the merged word, then go to RESP.
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-025 Each memory byte b_i = sram[addr+i] SHALL map to word bits [31-8i:24-8i].
REQ-026 Load results SHALL be:
- LW = {b3,b2,b1,b0};
- LH = sext{b1,b0}; LHU = zext{b1,b0};
- LB = sext b0; LBU = zext b0.
REQ-027 Store words SHALL be:
- SW writes {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
- SH writes {wdata[7:0], wdata[15:8], old[15:0]};
- SB writes {wdata[7:0], old[23:0]};
- old = the word captured in RMW_RD.
REQ-028 Latency from the accept edge to rsp_valid high SHALL be:
- 2 cycles for loads and SW;
- 3 cycles for SB and SH;
- 1 cycle for errors.
REQ-029 Outside RD and RMW_RD, mem_ren SHALL be 0; outside WR, mem_wen SHALL be 0; mem_ren and mem_wen SHALL never both be 1.
REQ-030 req_valid held while busy SHALL be ignored until the next IDLE cycle, with no request loss and no double accept.
REQ-031 A back-to-back request SHALL be accepted the cycle after RESP.
REQ-032 Misaligned but in-range addresses SHALL be legal.

Reset
REQ-033 With rst_n=0 at a clock edge, the state SHALL become IDLE.
REQ-034 Reset SHALL clear rsp_valid, rsp_err, rsp_rdata, mem_wen, mem_ren, mem_add, mem_datain and all captured request fields to 0.
REQ-035 Reset in RMW_RD SHALL abort the access with no memory write.
REQ-036 Reset in WR SHALL suppress mem_wen from the next cycle.
REQ-037 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-038 A shared package SHALL hold the state enum and the funct3 width-code constants, also used by the decoder.
REQ-039 One sub-module, lsu_byte_lane, SHALL perform the combinational byte swap, extension and merge.
REQ-040 The implementation SHALL need 120-400 lines of RTL.

Verification
REQ-041 SW addr 0x010, wdata 0x11223344; then LW addr 0x010 -> sram[0x10..0x13] = 44,33,22,11; rsp_rdata 0x11223344; load rsp_valid 2 cycles after accept.
REQ-042 SB addr 0x011, wdata 0xAA on the word above; then LW 0x010 -> 0x1122AA44; SB rsp_valid 3 cycles after accept.
REQ-043 Memory bytes 0x80,0xFF at 0x020 -> LB 0x020 = 0xFFFFFF80; LBU = 0x00000080; LH = 0xFFFFFF80; LHU = 0x0000FF80.
REQ-044 LW addr 0xFFD or funct3 011 -> rsp_err=1 one cycle after accept; mem_ren and mem_wen stay 0; rsp_rdata 0.
REQ-045 req_valid held high across 3 SW requests -> exactly 3 writes, each accept only in IDLE, correct values.
REQ-046 rst_n=0 during RMW_RD of an SB -> the target word is unchanged and req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit memory controller:
// FSM state encoding, RV32I width codes and the request legality rule.
package lsu_mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RMW_RD,
      WR,
      RESP
   } lsu_state_t;

   // RV32I funct3 width codes for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores only know signed-less widths B/H/W; loads also accept BU/HU.
   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      logic legal;
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      if (!we) begin
         legal = legal || (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      return legal;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_byte_lane.sv
// Byte lane for the LSU: translates between the memory's big-endian word
// layout (byte at the address in bits [31:24]) and the core's little-endian,
// LSB-aligned data. Produces the extended load result and the merged store word.
module lsu_byte_lane
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] store_word
);

   // mem_byte[i] is the byte at address+i; st_byte[i] is core data byte i
   logic [7:0] mem_byte [4];
   logic [7:0] st_byte  [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign mem_byte[gi] = word[31-8*gi -: 8];
      assign st_byte[gi]  = wdata[8*gi +: 8];
   end

   // Select extended load data and merged store word by access width
   always_comb begin
      load_data  = '0;
      store_word = '0;
      case (funct3)
         F3_B: begin
            load_data  = {{(DATA_WIDTH-8){mem_byte[0][7]}}, mem_byte[0]};
            store_word = DATA_WIDTH'({st_byte[0], word[23:0]});
         end
         F3_BU: begin
            load_data  = DATA_WIDTH'(mem_byte[0]);
         end
         F3_H: begin
            load_data  = {{(DATA_WIDTH-16){mem_byte[1][7]}}, mem_byte[1], mem_byte[0]};
            store_word = DATA_WIDTH'({st_byte[0], st_byte[1], word[15:0]});
         end
         F3_HU: begin
            load_data  = DATA_WIDTH'({mem_byte[1], mem_byte[0]});
         end
         F3_W: begin
            load_data  = DATA_WIDTH'({mem_byte[3], mem_byte[2], mem_byte[1], mem_byte[0]});
            store_word = DATA_WIDTH'({st_byte[0], st_byte[1], st_byte[2], st_byte[3]});
         end
         default: begin
            load_data  = '0;
            store_word = '0;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one core request at a time,
// performs a single read, a single write, or a read-modify-write for
// sub-word stores, and returns a one-cycle response pulse.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_add,
   output logic [DATA_WIDTH-1:0] mem_datain,
   input  logic [DATA_WIDTH-1:0] mem_dataout
);

   // Highest start address whose 4-byte word still fits in memory
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ~ADDR_WIDTH'(3);

   lsu_state_t            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  we_reg;
   logic [2:0]            funct3_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [DATA_WIDTH-1:0] word_reg;
   logic                  err_reg;

   logic                  accept;
   logic                  req_legal;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] store_word;

   assign req_ready = (state_reg == IDLE);
   assign accept    = req_valid && req_ready;
   assign req_legal = funct3_legal(req_we, req_funct3) && (req_addr <= ADDR_LAST);

   // The same captured word feeds load extraction and the RMW merge
   lsu_byte_lane #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_byte_lane (
      .funct3     (funct3_reg),
      .wdata      (wdata_reg),
      .word       (word_reg),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // State register; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture request fields at accept and the memory word during reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_reg   <= '0;
         we_reg     <= 1'b0;
         funct3_reg <= '0;
         wdata_reg  <= '0;
         word_reg   <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (accept) begin
            addr_reg   <= req_addr;
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            wdata_reg  <= req_wdata;
            err_reg    <= !req_legal;
         end
         if ((state_reg == RD) || (state_reg == RMW_RD)) begin
            word_reg <= mem_dataout;
         end
      end
   end

   // Next-state decode and per-state memory/response outputs
   always_comb begin
      state_next = state_reg;
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      mem_add    = '0;
      mem_datain = '0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (!req_legal) begin
                  state_next = RESP;
               end else if (!req_we) begin
                  state_next = RD;
               end else if (req_funct3 == F3_W) begin
                  state_next = WR;
               end else begin
                  state_next = RMW_RD;
               end
            end
         end
         RD: begin
            mem_ren    = 1'b1;
            mem_add    = addr_reg;
            state_next = RESP;
         end
         RMW_RD: begin
            mem_ren    = 1'b1;
            mem_add    = addr_reg;
            state_next = WR;
         end
         WR: begin
            mem_wen    = 1'b1;
            mem_add    = addr_reg;
            mem_datain = store_word;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            rsp_err    = err_reg;
            if (!err_reg && !we_reg) begin
               rsp_rdata = load_data;
            end
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-addressed memory model driven
// by the memory port, plus a little-endian reference memory and access
// rules used to predict every response.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_ren;
   logic        mem_wen;
   logic [11:0] mem_add;
   logic [31:0] mem_datain;
   logic [31:0] mem_dataout;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(12)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .mem_ren     (mem_ren),
      .mem_wen     (mem_wen),
      .mem_add     (mem_add),
      .mem_datain  (mem_datain),
      .mem_dataout (mem_dataout)
   );

   // Physical memory: byte at mem_add sits in word bits [31:24]
   logic [7:0] sram    [0:4095];
   logic [7:0] ref_mem [0:4095];
   logic       load_mem;

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 4096; i++) sram[i] <= 8'(i * 7 + 3);
      end else if (mem_wen) begin
         for (int i = 0; i < 4; i++) sram[12'(mem_add + 12'(i))] <= mem_datain[31-8*i -: 8];
      end
   end

   always_comb begin
      mem_dataout = {sram[mem_add], sram[mem_add + 12'd1], sram[mem_add + 12'd2], sram[mem_add + 12'd3]};
   end

   // Activity monitors
   int cycle_cnt  = 0;
   int rd_count   = 0;
   int wr_count   = 0;
   int both_count = 0;
   int acc_log[$];

   always @(posedge clk) begin
      if (rst_n && req_valid && req_ready) acc_log.push_back(cycle_cnt);
      if (mem_ren) rd_count++;
      if (mem_wen) wr_count++;
      if (mem_ren && mem_wen) both_count++;
      cycle_cnt++;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (little-endian byte memory) ----------------
   function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [11:0] a);
      if (int'(a) > 4096 - 4) return 1'b0;
      if (we) return (f3 <= 3'd2);
      return !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
   endfunction

   function automatic int ref_nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [11:0] a);
      logic [31:0] v;
      int n;
      n = ref_nbytes(f3);
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(a + 12'(i))]) << (8 * i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
      for (int i = 0; i < ref_nbytes(f3); i++) ref_mem[12'(a + 12'(i))] = wd[8*i +: 8];
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] wd, output logic [31:0] rdata,
                         output logic err, output int lat);
      int n;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   task automatic run_and_check(input string tag, input logic we, input logic [2:0] f3,
                                input logic [11:0] a, input logic [31:0] wd,
                                output logic [31:0] got);
      bit          legal;
      int          exp_lat, lat, rd0, wr0;
      logic [31:0] exp_data;
      logic        err;
      legal    = ref_legal(we, f3, a);
      exp_lat  = !legal ? 1 : (!we ? 2 : (f3 == 3'd2 ? 2 : 3));
      exp_data = (legal && !we) ? ref_load(f3, a) : 32'd0;
      rd0 = rd_count;
      wr0 = wr_count;
      do_req(we, f3, a, wd, got, err, lat);
      check($sformatf("%s_err", tag), 32'(err), 32'(!legal));
      check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_rdata", tag), got, exp_data);
      check($sformatf("%s_reads", tag), 32'(rd_count - rd0), 32'(legal && (!we || f3 != 3'd2)));
      check($sformatf("%s_writes", tag), 32'(wr_count - wr0), 32'(legal && we));
      @(posedge clk);
      #1;
      check($sformatf("%s_pulse_end", tag), 32'(rsp_valid), 32'd0);
      if (legal && we) ref_store(f3, a, wd);
      $display("txn %s we=%0d f3=%0d addr=0x%03h wdata=0x%08h -> err=%0d lat=%0d rdata=0x%08h",
               tag, we, f3, a, wd, err, lat, got);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] got;
      logic [7:0]  saved [4];
      int          n, w0, mism;
      logic [31:0] hw [3];

      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 7 + 3);
      rst_n      = 1'b0;
      load_mem   = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 12'd0;
      req_wdata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      load_mem = 1'b0;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_ren", 32'(mem_ren), 32'd0);
      check("rst_mem_wen", 32'(mem_wen), 32'd0);
      check("rst_mem_add", 32'(mem_add), 32'd0);
      check("rst_mem_datain", mem_datain, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_release_ready", 32'(req_ready), 32'd1);

      // word store then load back
      run_and_check("sw_0x010", 1'b1, 3'd2, 12'h010, 32'h1122_3344, got);
      check("sw_byte10", 32'(sram[12'h010]), 32'h44);
      check("sw_byte11", 32'(sram[12'h011]), 32'h33);
      check("sw_byte12", 32'(sram[12'h012]), 32'h22);
      check("sw_byte13", 32'(sram[12'h013]), 32'h11);
      run_and_check("lw_0x010", 1'b0, 3'd2, 12'h010, 32'd0, got);
      check("lw_0x010_const", got, 32'h1122_3344);

      // byte store merge
      run_and_check("sb_0x011", 1'b1, 3'd0, 12'h011, 32'h0000_00AA, got);
      run_and_check("lw_after_sb", 1'b0, 3'd2, 12'h010, 32'd0, got);
      check("lw_after_sb_const", got, 32'h1122_AA44);

      // sign/zero extension on bytes 0x80,0xFF at 0x020
      run_and_check("sh_0x020", 1'b1, 3'd1, 12'h020, 32'h0000_FF80, got);
      run_and_check("lb_0x020", 1'b0, 3'd0, 12'h020, 32'd0, got);
      check("lb_const", got, 32'hFFFF_FF80);
      run_and_check("lbu_0x020", 1'b0, 3'd4, 12'h020, 32'd0, got);
      check("lbu_const", got, 32'h0000_0080);
      run_and_check("lh_0x020", 1'b0, 3'd1, 12'h020, 32'd0, got);
      check("lh_const", got, 32'hFFFF_FF80);
      run_and_check("lhu_0x020", 1'b0, 3'd5, 12'h020, 32'd0, got);
      check("lhu_const", got, 32'h0000_FF80);

      // errors and address boundary
      run_and_check("lw_0xffd_err", 1'b0, 3'd2, 12'hFFD, 32'd0, got);
      run_and_check("load_f3_011_err", 1'b0, 3'd3, 12'h000, 32'd0, got);
      run_and_check("store_f3_100_err", 1'b1, 3'd4, 12'h100, 32'hDEAD_BEEF, got);
      run_and_check("sw_0xffc", 1'b1, 3'd2, 12'hFFC, 32'hCAFE_F00D, got);
      run_and_check("lw_0xffc", 1'b0, 3'd2, 12'hFFC, 32'd0, got);
      run_and_check("sw_misaligned", 1'b1, 3'd2, 12'h033, 32'h0102_0304, got);
      run_and_check("lhu_misaligned", 1'b0, 3'd5, 12'h035, 32'd0, got);

      // req_valid held high across three stores
      @(negedge clk);
      w0 = wr_count;
      acc_log.delete();
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         hw[k]      = $urandom;
         req_we     = 1'b1;
         req_funct3 = 3'd2;
         req_addr   = 12'h200 + 12'(8 * k);
         req_wdata  = hw[k];
         n = 0;
         while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("held_ready_wait", 32'(req_ready), 32'd1);
         @(posedge clk);
         #1;
         ref_store(3'd2, 12'h200 + 12'(8 * k), hw[k]);
         if (k == 2) begin
            req_valid = 1'b0;
         end else begin
            @(negedge clk);
            check("held_busy_ready", 32'(req_ready), 32'd0);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("held_accepts", 32'(acc_log.size()), 32'd3);
      if (acc_log.size() == 3) begin
         check("held_gap01", 32'(acc_log[1] - acc_log[0]), 32'd3);
         check("held_gap12", 32'(acc_log[2] - acc_log[1]), 32'd3);
      end
      check("held_writes", 32'(wr_count - w0), 32'd3);
      $display("txn held_sw accepts=%0d writes=%0d", acc_log.size(), wr_count - w0);
      for (int k = 0; k < 3; k++) begin
         run_and_check($sformatf("held_lw%0d", k), 1'b0, 3'd2, 12'h200 + 12'(8 * k), 32'd0, got);
         check($sformatf("held_lw%0d_const", k), got, hw[k]);
      end

      // randomized mix against the reference model
      for (int k = 0; k < 50; k++) begin
         logic [11:0] a;
         logic [2:0]  f3;
         logic        we;
         a  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4086, 4095)) : 12'($urandom_range(0, 255));
         f3 = 3'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         run_and_check($sformatf("rnd%0d", k), we, f3, a, $urandom, got);
      end

      // reset while an SB is in its read-modify-write read
      for (int i = 0; i < 4; i++) saved[i] = sram[12'h040 + 12'(i)];
      w0 = wr_count;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 12'h040;
      req_wdata  = 32'h0000_005A;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rmw_abort_reading", 32'(mem_ren), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rmw_abort_wen", 32'(mem_wen), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rmw_abort_ready", 32'(req_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("rmw_abort_writes", 32'(wr_count - w0), 32'd0);
      for (int i = 0; i < 4; i++)
         check($sformatf("rmw_abort_byte%0d", i), 32'(sram[12'h040 + 12'(i)]), 32'(saved[i]));
      $display("txn sb_reset_abort addr=0x040 writes=%0d", wr_count - w0);

      // whole-memory agreement and port exclusivity
      mism = 0;
      for (int i = 0; i < 4096; i++) if (sram[i] !== ref_mem[i]) mism++;
      check("mem_final_mismatches", 32'(mism), 32'd0);
      check("ren_wen_overlap", 32'(both_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
